// File: rtl/l1_d_l2_bridge.sv
// l1_d_l2_bridge: splits L1 line requests (refill / dirty write-back) into BUS_BITS beats on
// the L2 memory bus and reassembles refill beats into a full line.
// Optional build macro: L1_L2_PERF_CNT_EN adds saturating rd_cnt / wb_cnt transaction counters.
module l1_d_l2_bridge #(
  parameter int unsigned LINE_BITS   = 512,
  parameter int unsigned BUS_BITS    = 128,
  parameter int unsigned TAG_BITS    = 21,
  parameter int unsigned INDEX_BITS  = 5,
  parameter int unsigned OFFSET_BITS = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  read_L1_L2,
  input  logic                  write_L1_L2,
  input  logic [INDEX_BITS-1:0] index_L1_L2,
  input  logic [TAG_BITS-1:0]   tag_L1_L2,
  input  logic [TAG_BITS-1:0]   write_tag_L1_L2,
  input  logic [LINE_BITS-1:0]  write_data_L1_L2,
  output logic                  ready_L2_L1,
  output logic [LINE_BITS-1:0]  read_data_L2_L1,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [BUS_BITS-1:0]   mem_wdata,
  input  logic                  mem_ack,
  input  logic [BUS_BITS-1:0]   mem_rdata
`ifdef L1_L2_PERF_CNT_EN
  ,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wb_cnt
`endif
);

  localparam int unsigned BEATS  = LINE_BITS / BUS_BITS;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BYTE_W = $clog2(BUS_BITS / 8);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_t;

  state_t                  state;
  logic [BEAT_W-1:0]       beat;
  logic [TAG_BITS-1:0]     tag_lat;
  logic [INDEX_BITS-1:0]   index_lat;
  logic [LINE_BITS-1:0]    line_buf;
  logic [BEAT_W-1:0]       next_beat;
  logic [BUS_BITS-1:0]     next_slice;
  logic                    last_beat;

  // Beat byte address: line address with the beat number in the upper offset bits.
  function automatic logic [31:0] beat_addr(input logic [TAG_BITS-1:0]   t,
                                            input logic [INDEX_BITS-1:0] i,
                                            input logic [BEAT_W-1:0]     b);
    logic [OFFSET_BITS-1:0] off;
    off = OFFSET_BITS'({b, {BYTE_W{1'b0}}});
    return {t, i, off};
  endfunction

  // Next beat number and the victim slice it will drive.
  always_comb begin
    next_beat  = beat + BEAT_W'(1);
    last_beat  = (beat == BEAT_W'(BEATS - 1));
    next_slice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (next_beat == BEAT_W'(b)) next_slice = line_buf[b*BUS_BITS +: BUS_BITS];
    end
  end

  // Transfer FSM with registered bus and L1-side outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= StIdle;
      beat            <= '0;
      tag_lat         <= '0;
      index_lat       <= '0;
      line_buf        <= '0;
      ready_L2_L1     <= 1'b0;
      read_data_L2_L1 <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
`ifdef L1_L2_PERF_CNT_EN
      rd_cnt          <= '0;
      wb_cnt          <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          // Write-back wins over a simultaneous refill; the read stays pending upstream.
          if (write_L1_L2) begin
            tag_lat   <= write_tag_L1_L2;
            index_lat <= index_L1_L2;
            line_buf  <= write_data_L1_L2;
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= beat_addr(write_tag_L1_L2, index_L1_L2, '0);
            mem_wdata <= write_data_L1_L2[BUS_BITS-1:0];
            state     <= StXfer;
          end else if (read_L1_L2) begin
            tag_lat   <= tag_L1_L2;
            index_lat <= index_L1_L2;
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= beat_addr(tag_L1_L2, index_L1_L2, '0);
            mem_wdata <= '0;
            state     <= StXfer;
          end
        end
        StXfer: begin
          if (mem_req && mem_ack) begin
            if (!mem_we) begin
              for (int b = 0; b < BEATS; b++) begin
                if (beat == BEAT_W'(b)) read_data_L2_L1[b*BUS_BITS +: BUS_BITS] <= mem_rdata;
              end
            end
            if (last_beat) begin
              mem_req     <= 1'b0;
              beat        <= '0;
              ready_L2_L1 <= 1'b1;
              state       <= StDone;
            end else begin
              beat      <= next_beat;
              mem_addr  <= beat_addr(tag_lat, index_lat, next_beat);
              mem_wdata <= mem_we ? next_slice : '0;
            end
          end
        end
        StDone: begin
          ready_L2_L1 <= 1'b0;
          state       <= StIdle;
`ifdef L1_L2_PERF_CNT_EN
          if (mem_we) begin
            if (wb_cnt != 32'hFFFF_FFFF) wb_cnt <= wb_cnt + 32'd1;
          end else begin
            if (rd_cnt != 32'hFFFF_FFFF) rd_cnt <= rd_cnt + 32'd1;
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_d_l2_bridge.sv
// Self-checking bench for l1_d_l2_bridge: directed vector table, random transactions checked
// against an address/line model, and hand-written reset corner cases.
module tb_l1_d_l2_bridge;

  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         nrst;
  logic         read_L1_L2, write_L1_L2;
  logic [4:0]   index_L1_L2;
  logic [20:0]  tag_L1_L2, write_tag_L1_L2;
  logic [511:0] write_data_L1_L2;
  logic         ready_L2_L1;
  logic [511:0] read_data_L2_L1;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;
`ifdef L1_L2_PERF_CNT_EN
  logic [31:0]  rd_cnt, wb_cnt;
`endif

  l1_d_l2_bridge dut (
    .clk              (clk),
    .nrst             (nrst),
    .read_L1_L2       (read_L1_L2),
    .write_L1_L2      (write_L1_L2),
    .index_L1_L2      (index_L1_L2),
    .tag_L1_L2        (tag_L1_L2),
    .write_tag_L1_L2  (write_tag_L1_L2),
    .write_data_L1_L2 (write_data_L1_L2),
    .ready_L2_L1      (ready_L2_L1),
    .read_data_L2_L1  (read_data_L2_L1),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata)
`ifdef L1_L2_PERF_CNT_EN
    ,
    .rd_cnt           (rd_cnt),
    .wb_cnt           (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_wait = 0;
  bit          stray    = 0;
  logic [31:0] salt     = 0;
  logic [511:0] last_line = '0;
  int          n_rd = 0, n_wr = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // L2 memory contents as seen by the bench.
  function automatic logic [127:0] rdata_for(input logic [31:0] a);
    if (salt == 0) return {4{30'd0, a[5:4]}};
    return {4{a ^ salt}};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [20:0] t, input logic [4:0] i, input int k);
    return (32'(t) << 11) | (32'(i) << 6) | (32'(k) << 4);
  endfunction

  function automatic logic [511:0] exp_line(input logic [20:0] t, input logic [4:0] i);
    logic [511:0] l;
    for (int b = 0; b < BEATS; b++) l[b*128 +: 128] = rdata_for(exp_addr(t, i, b));
    return l;
  endfunction

  // L2 responder: acks each beat after ack_wait idle cycles; stray keeps ack tied high.
  initial begin
    int cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!nrst) cnt = 0;
      if (nrst && (stray || (mem_req && cnt >= ack_wait))) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_for(mem_addr);
        cnt       = 0;
      end else begin
        mem_ack = 1'b0;
        if (mem_req) cnt++;
      end
    end
  end

  // One transaction phase, started mid-cycle just before its accept edge.
  task automatic run_phase(input bit we, input logic [20:0] t, input logic [4:0] ix,
                           input logic [511:0] wl, input int wt, input bit scramble,
                           input string nm, output logic [31:0] fa, output logic [31:0] la);
    int k = 0, c = 0, budget;
    bit seen = 0;
    budget = BEATS * (wt + 1) + 20;
    fa = '0;
    la = '0;
    while (!seen && c < budget) begin
      @(negedge clk); #2;
      c++;
      if (scramble && c == 1) begin
        tag_L1_L2        = 21'($urandom);
        write_tag_L1_L2  = 21'($urandom);
        index_L1_L2      = 5'($urandom);
        write_data_L1_L2 = {16{$urandom}};
      end
      if (ready_L2_L1) begin
        seen = 1;
        chk({nm, " ready latency"}, 512'(c), 512'(BEATS * (wt + 1) + 1));
        chk({nm, " beat count"}, 512'(k), 512'(BEATS));
        chk({nm, " req low at ready"}, 512'(mem_req), 512'(0));
        if (!we) last_line = exp_line(t, ix);
        chk({nm, " read line"}, read_data_L2_L1, last_line);
        if (we) n_wr++; else n_rd++;
      end else if (mem_req) begin
        if (k < BEATS) begin
          chk({nm, " addr"}, 512'(mem_addr), 512'(exp_addr(t, ix, k)));
          chk({nm, " we"}, 512'(mem_we), 512'(we));
          if (we) chk({nm, " wdata"}, 512'(mem_wdata), 512'(wl[k*128 +: 128]));
          if (k == 0) fa = mem_addr;
          la = mem_addr;
        end
        if (mem_ack) k++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no ready within %0d cycles, got 0 expected 1", nm, budget);
    end
    @(negedge clk); #2;
    chk({nm, " ready one cycle"}, 512'(ready_L2_L1), 512'(0));
    chk({nm, " idle gap req"}, 512'(mem_req), 512'(0));
  endtask

  task automatic do_txn(input bit rd, input bit wr, input logic [20:0] t, input logic [20:0] wt_tag,
                        input logic [4:0] ix, input logic [511:0] wl, input int wt,
                        input string nm, output logic [31:0] fa, output logic [31:0] la);
    logic [31:0] f2, l2;
    ack_wait         = wt;
    tag_L1_L2        = t;
    write_tag_L1_L2  = wt_tag;
    index_L1_L2      = ix;
    write_data_L1_L2 = wl;
    read_L1_L2       = rd;
    write_L1_L2      = wr;
    fa = '0;
    la = '0;
    if (wr) begin
      run_phase(1'b1, wt_tag, ix, wl, wt, !rd, {nm, ".wr"}, fa, la);
      write_L1_L2 = 1'b0;
    end
    if (rd) begin
      run_phase(1'b0, t, ix, wl, wt, !wr, {nm, ".rd"}, f2, l2);
      if (!wr) begin fa = f2; la = l2; end
      read_L1_L2 = 1'b0;
    end
    @(negedge clk); #2;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    bit          stray;
    logic [20:0] tag;
    logic [20:0] wtag;
    logic [4:0]  idx;
    int          wt;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] fa, la;
    logic [511:0] wl;
    vecs[0] = '{1, 0, 1, 21'h0ABCD, 21'h0, 5'd3, 0, 32'h055E_68C0, 32'h055E_68F0};
    vecs[1] = '{0, 1, 0, 21'h0, 21'h1FFFFF, 5'd31, 3, 32'hFFFF_FFC0, 32'hFFFF_FFF0};
    vecs[2] = '{1, 0, 0, 21'h0, 21'h0, 5'd0, 1, 32'h0000_0000, 32'h0000_0030};
    vecs[3] = '{0, 1, 0, 21'h0, 21'h000001, 5'd1, 0, 32'h0000_0840, 32'h0000_0870};
    vecs[4] = '{1, 1, 0, 21'h12345, 21'h00FF0, 5'd7, 0, 32'h007F_81C0, 32'h007F_81F0};

    nrst = 1'b1;
    read_L1_L2 = 0; write_L1_L2 = 0; index_L1_L2 = 0; tag_L1_L2 = 0;
    write_tag_L1_L2 = 0; write_data_L1_L2 = 0;

    // Asynchronous reset mid-cycle, no clock edge in between.
    #3 nrst = 1'b0;
    #1;
    chk("rst ready", 512'(ready_L2_L1), 512'(0));
    chk("rst read_data", read_data_L2_L1, 512'(0));
    chk("rst mem_req", 512'(mem_req), 512'(0));
    chk("rst mem_we", 512'(mem_we), 512'(0));
    chk("rst mem_addr", 512'(mem_addr), 512'(0));
    chk("rst mem_wdata", 512'(mem_wdata), 512'(0));
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk); #2;

    // Directed vector table.
    for (int v = 0; v < 5; v++) begin
      wl = {16{$urandom}};
      stray = vecs[v].stray;
      do_txn(vecs[v].rd, vecs[v].wr, vecs[v].tag, vecs[v].wtag, vecs[v].idx, wl, vecs[v].wt,
             $sformatf("vec%0d", v), fa, la);
      stray = 0;
      chk($sformatf("vec%0d first addr", v), 512'(fa), 512'(vecs[v].first));
      chk($sformatf("vec%0d last addr", v), 512'(la), 512'(vecs[v].last));
    end

    // Reset during transfer after beat 1 is acknowledged.
    begin
      int k = 0, c = 0;
      salt = 32'h5A5A_0F0F;
      ack_wait = 1;
      tag_L1_L2 = 21'h0F00F;
      index_L1_L2 = 5'd9;
      read_L1_L2 = 1'b1;
      while (k < 2 && c < 40) begin
        @(negedge clk); #2;
        c++;
        if (mem_req && mem_ack) k++;
      end
      chk("abort beats seen", 512'(k), 512'(2));
      @(posedge clk); #3;
      nrst = 1'b0;
      #1;
      chk("abort mem_req", 512'(mem_req), 512'(0));
      chk("abort ready", 512'(ready_L2_L1), 512'(0));
      chk("abort read_data", read_data_L2_L1, 512'(0));
      chk("abort mem_addr", 512'(mem_addr), 512'(0));
      read_L1_L2 = 1'b0;
      last_line = '0;
      n_rd = 0;
      n_wr = 0;
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk); #2;
      chk("post abort ready", 512'(ready_L2_L1), 512'(0));
      do_txn(1, 0, 21'h0F00F, 21'h0, 5'd9, '0, 1, "restart", fa, la);
      chk("restart first addr", 512'(fa), 512'(32'h0780_7A40));
    end

    // Random transactions against the model.
    for (int r = 0; r < 24; r++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      salt = $urandom | 32'h1;
      wl = {16{$urandom}};
      do_txn(kind != 1, kind != 0, 21'($urandom), 21'($urandom), 5'($urandom), wl,
             int'($urandom_range(0, 3)), $sformatf("rnd%0d", r), fa, la);
    end

`ifdef L1_L2_PERF_CNT_EN
    chk("rd_cnt", 512'(rd_cnt), 512'(n_rd));
    chk("wb_cnt", 512'(wb_cnt), 512'(n_wr));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_d_l2_bridge.md
Name: l1_d_l2_bridge

Overview:
Downstream neighbour of the L1 data-cache controller. Converts its line-granular L1→L2 requests (refill read, dirty-victim write-back) into a sequence of fixed-width beats on the narrower L2 memory bus. Assembles refill beats into a full line. Returns a single-cycle ready_L2_L1 pulse per completed transaction.

Parameters:
LINE_BITS, 512, cache line width (64 B).
BUS_BITS, 128, L2 bus data width per beat; BEATS = LINE_BITS/BUS_BITS (default 4).
TAG_BITS, 21, tag width.
INDEX_BITS, 5, set index width.
OFFSET_BITS, 6, line byte-offset width; TAG_BITS+INDEX_BITS+OFFSET_BITS = 32.

Ports:
clk  in  1  clock, rising edge.
nrst  in  1  asynchronous active-low reset.
read_L1_L2  in  1  refill request, level, held until ready_L2_L1 is seen.
write_L1_L2  in  1  write-back request, level, held until ready_L2_L1 is seen.
index_L1_L2  in  INDEX_BITS  set index for both request types.
tag_L1_L2  in  TAG_BITS  refill tag.
write_tag_L1_L2  in  TAG_BITS  victim tag for write-back.
write_data_L1_L2  in  LINE_BITS  victim line data.
ready_L2_L1  out  1  one-cycle transaction-complete pulse.
read_data_L2_L1  out  LINE_BITS  assembled refill line.
mem_req  out  1  beat request.
mem_we  out  1  1 = write beat, 0 = read beat.
mem_addr  out  32  beat byte address.
mem_wdata  out  BUS_BITS  write beat data.
mem_ack  in  1  beat accepted / read data valid.
mem_rdata  in  BUS_BITS  read beat data, valid with mem_ack.

Behaviour:
- Reset (nrst=0, async): state IDLE, beat counter 0, all outputs 0 including read_data_L2_L1.
- States: IDLE, XFER, DONE.
- IDLE: at a clock edge with write_L1_L2=1, latch {write_tag, index, write_data}. Set mem_we=1 and go to XFER.
- IDLE, read only: at a clock edge with write_L1_L2=0 and read_L1_L2=1, latch {tag, index}. Set mem_we=0 and go to XFER.
- IDLE, both asserted: write wins. The controller re-issues the read after the write's ready pulse.
- XFER: mem_req=1 from the first cycle after acceptance.
- XFER beat address: mem_addr = {latched tag, latched index, beat[log2(BEATS)-1:0], log2(BUS_BITS/8) zero bits}. Beats run in ascending order from 0.
- XFER write data: mem_wdata = latched line slice [beat*BUS_BITS +: BUS_BITS].
- XFER acknowledge: an edge with mem_req&mem_ack completes the current beat.
  - Read beat: mem_rdata is written into read_data_L2_L1 slice [beat].
  - Not the last beat: beat increments, mem_req stays 1, and address/data update in the same cycle.
  - Last beat (beat = BEATS-1): go to DONE, mem_req=0, beat=0.
- While mem_ack=0: mem_req, mem_we, mem_addr and mem_wdata are held stable. There is no timeout.
- DONE: ready_L2_L1=1 for exactly one cycle, then IDLE. mem_req=0.
- Request retirement: the controller deasserts on the edge where it samples ready. IDLE evaluates requests from the following cycle, giving a 1-cycle minimum gap between transactions.
- Latency with zero-wait acks: accept edge T; beats complete at T+1..T+BEATS; ready high in cycle T+BEATS+1.
- read_data_L2_L1 is valid while ready_L2_L1=1. It holds until the next read beat overwrites it and is not cleared by write transactions.
- Request input changes during XFER/DONE are ignored; latched values are used.
- Reset mid-transfer: immediate abort, all outputs 0, partially assembled line discarded. L2 must tolerate a dropped mem_req.
- A mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro L1_L2_PERF_CNT_EN.
- Defined: adds outputs rd_cnt[31:0] and wb_cnt[31:0], reset to 0.
  - Each increments by 1 in the DONE cycle of a read or write transaction respectively.
  - Each saturates at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset values: assert nrst=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Refill, zero-wait acks:
  - Stimulus: read_L1_L2=1, tag=21'h0ABCD, index=5'd3, mem_ack tied 1, mem_rdata = beat number replicated.
  - Response: mem_addr 0x055E_68C0, 0x055E_68D0, 0x055E_68E0, 0x055E_68F0 on consecutive cycles.
  - Response: ready_L2_L1 pulses one cycle, 5 cycles after accept; read_data_L2_L1 slices = 0,1,2,3.
- Write-back with wait states:
  - Stimulus: write_L1_L2=1, write_tag=21'h1FFFFF, index=5'd31, mem_ack high 3 cycles after each mem_req beat.
  - Response: mem_we=1; mem_addr/mem_wdata stable across waits; final beat address 0xFFFF_FFF0.
  - Response: single ready pulse after 4 acks.
- Simultaneous read+write:
  - Stimulus: both asserted.
  - Response: write beats first (mem_we=1), ready pulse; controller drops write.
  - Response: read transaction starts after a 1-cycle IDLE gap; second ready pulse follows.
- Reset during XFER: nrst low after beat 1 ack -> mem_req=0, beat 0, no ready. A following read restarts at beat 0.
- With L1_L2_PERF_CNT_EN:
  - Stimulus: 3 reads and 2 write-backs.
  - Response: rd_cnt=3, wb_cnt=2.
  - Response: preloaded rd_cnt=32'hFFFF_FFFF stays saturated after another read.
